sseg_scan_ctrl: RTL and testbench



---
 rtl/sseg_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Brief    : Time-multiplexed scan controller for an 8-digit common-anode
//            seven-segment display. Shadow registers (hex nibbles, decimal
//            points, digit mask) are reloaded only at frame boundaries via a
//            LOAD_REQ/LOAD_ACK handshake. Each digit slot begins with an
//            all-anodes-off blank interval to avoid ghosting.
// Options  : SSEG_LZ_BLANK_EN - when defined, leading zeros are suppressed at
//            load time (digit 0 always shown).
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl #(
    parameter int NUM_DIG   = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP,
    input  logic [7:0]  EN_MASK,
    input  logic        LOAD_REQ,
    output logic        LOAD_ACK,
    output logic [7:0]  SSEG_CA,
    output logic [7:0]  SSEG_AN,
    output logic        FRAME
);

    localparam int                 c_DIV_W      = $clog2(SCAN_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_BLANK_LAST = c_DIV_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [2:0]         c_IDX_LAST   = 3'(NUM_DIG - 1);
    localparam logic               c_NO_BLANK   = (BLANK_CYC == 0);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [2:0]         r_idx;
    logic [31:0]        r_data;
    logic [7:0]         r_dp;
    logic [7:0]         r_mask;
    logic [7:0]         r_an;
    logic [7:0]         r_ca;
    logic               r_frame;
    logic               r_ack;

    logic               w_slot_end;
    logic               w_frame_end;
    logic               w_load;
    logic [7:0]         w_load_mask;
    logic [7:0]         w_onehot;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
    logic [7:0]         w_an_nxt;
    logic [7:0]         w_ca_nxt;

    assign w_slot_end  = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_load      = w_frame_end && LOAD_REQ;

`ifdef SSEG_LZ_BLANK_EN
    logic [7:0] w_lz_keep;

    // Keep digit i only if some nibble at or above i is nonzero; digit 0 always kept
    always_comb begin
        w_lz_keep    = 8'h00;
        w_lz_keep[7] = |DATA[31:28];
        for (int i = 6; i >= 1; i--) begin
            w_lz_keep[i] = w_lz_keep[i+1] | (|DATA[4*i +: 4]);
        end
        w_lz_keep[0] = 1'b1;
        w_load_mask  = EN_MASK & w_lz_keep;
    end
`else
    assign w_load_mask = EN_MASK;
`endif

    // Slot divider and digit index; index advances when a slot completes
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_div_cnt <= '0;
            r_idx     <= 3'd0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pre-register pin values for the digit in the current slot
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 8'hFF;
        w_ca_nxt    = 8'hFF;
        w_onehot    = 8'b1 << r_idx;
        w_nib       = r_data[{r_idx, 2'b00} +: 4];
        w_seg       = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
        case (r_state)
            BLANK: begin
                if (c_NO_BLANK || (r_div_cnt == c_BLANK_LAST)) begin
                    w_state_nxt = DRIVE;
                end
            end
            default: begin
                if (w_slot_end) begin
                    w_state_nxt = c_NO_BLANK ? DRIVE : BLANK;
                end
                if (|(r_mask & w_onehot)) begin
                    w_an_nxt = ~w_onehot;
                    w_ca_nxt = ~{|(r_dp & w_onehot), w_seg};
                end
            end
        endcase
    end

    // Shadow registers change only on reset or an accepted boundary load
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_data <= 32'h0;
            r_dp   <= 8'h00;
            r_mask <= 8'h00;
        end else if (w_load) begin
            r_data <= DATA;
            r_dp   <= DP;
            r_mask <= w_load_mask;
        end
    end

    // Registered pins and one-cycle FRAME/LOAD_ACK pulses
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_an    <= 8'hFF;
            r_ca    <= 8'hFF;
            r_frame <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_an    <= w_an_nxt;
            r_ca    <= w_ca_nxt;
            r_frame <= w_frame_end;
            r_ack   <= w_load;
        end
    end

    assign SSEG_AN  = r_an;
    assign SSEG_CA  = r_ca;
    assign FRAME    = r_frame;
    assign LOAD_ACK = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Brief    : Self-checking bench for sseg_scan_ctrl (NUM_DIG=8, SCAN_DIV=8,
//            BLANK_CYC=2). A cycle model pushes expected pin values into a
//            queue on each rising edge; a monitor pops and compares them on
//            the falling edge. Load vectors come from a table; reset and
//            mid-frame request sequences are written out by hand.
//            Honours SSEG_LZ_BLANK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int P_NUM   = 8;
    localparam int P_DIV   = 8;
    localparam int P_BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en_mask;
    logic        load_req;
    logic        load_ack;
    logic [7:0]  sseg_ca;
    logic [7:0]  sseg_an;
    logic        frame;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIG   (P_NUM),
        .SCAN_DIV  (P_DIV),
        .BLANK_CYC (P_BLANK)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .DATA     (data),
        .DP       (dp),
        .EN_MASK  (en_mask),
        .LOAD_REQ (load_req),
        .LOAD_ACK (load_ack),
        .SSEG_CA  (sseg_ca),
        .SSEG_AN  (sseg_an),
        .FRAME    (frame)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ca;
        logic       fr;
        logic       ack;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
        logic [7:0]  seen;
        logic [7:0]  d0;
        logic [7:0]  d2;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int n_printed = 0;

    logic [7:0] seen_low;
    int         frame_cnt;
    int         ack_cnt;
    logic [7:0] d0_ca;
    logic [7:0] d2_ca;
    logic [7:0] d7_ca;

    logic [5:0]  m_pos;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tab[n];
    endfunction

    function automatic logic [7:0] lz_keep(input logic [31:0] d);
        logic [7:0] keep;
        int hi;
        keep = 8'hFF;
`ifdef SSEG_LZ_BLANK_EN
        hi = 0;
        for (int i = 0; i < 8; i++) if (d[4*i +: 4] != 4'h0) hi = i;
        keep = 8'h00;
        for (int i = 0; i <= hi; i++) keep[i] = 1'b1;
`else
        hi = 0;
        if (d == 32'h0) keep = 8'hFF;
`endif
        return keep;
    endfunction

    // Reference model: frame position counter, shadow copy, expected pins
    always @(posedge clk) begin : model
        exp_t       e;
        logic [2:0] dg;
        e = '{an: 8'hFF, ca: 8'hFF, fr: 1'b0, ack: 1'b0};
        if (!rst_n) begin
            m_pos  <= 6'd0;
            m_data <= 32'h0;
            m_dp   <= 8'h00;
            m_mask <= 8'h00;
        end else begin
            dg = m_pos[5:3];
            if ((int'(m_pos[2:0]) >= P_BLANK) && m_mask[dg]) begin
                e.an = ~(8'd1 << dg);
                e.ca = ~{m_dp[dg], seg7(m_data[4*dg +: 4])};
            end
            e.fr  = (m_pos == 6'd63);
            e.ack = e.fr && load_req;
            if (e.ack) begin
                m_data <= data;
                m_dp   <= dp;
                m_mask <= en_mask & lz_keep(data);
            end
            m_pos <= m_pos + 6'd1;
        end
        sb_q.push_back(e);
    end

    // Monitor: compare pins against the model, gather per-frame observations
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = '{an: sseg_an, ca: sseg_ca, fr: frame, ack: load_ack};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                if (n_printed < 20) begin
                    n_printed++;
                    $display("FAIL sb t=%0t got an=%h ca=%h fr=%b ack=%b want an=%h ca=%h fr=%b ack=%b",
                             $time, a.an, a.ca, a.fr, a.ack, e.an, e.ca, e.fr, e.ack);
                end
            end
            seen_low  = seen_low | ~sseg_an;
            frame_cnt = frame_cnt + int'(frame);
            ack_cnt   = ack_cnt + int'(load_ack);
            if (sseg_an == 8'hFE) d0_ca = sseg_ca;
            if (sseg_an == 8'hFB) d2_ca = sseg_ca;
            if (sseg_an == 8'h7F) d7_ca = sseg_ca;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic clear_acc();
        seen_low  = 8'h00;
        frame_cnt = 0;
        ack_cnt   = 0;
        d0_ca     = 8'hFF;
        d2_ca     = 8'hFF;
        d7_ca     = 8'hFF;
    endtask

    task automatic wait_ack(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (load_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        check({name, "_frame"}, 32'(frame), 32'd1);
    endtask

    task automatic wait_an(input logic [7:0] v, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (sseg_an === v) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
        data     = d;
        dp       = p;
        en_mask  = m;
        load_req = 1'b1;
        wait_ack("load_ack");
        load_req = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_an [11];
        logic [7:0] exp_ca [11];

        rst_n    = 1'b0;
        data     = 32'h0;
        dp       = 8'h00;
        en_mask  = 8'h00;
        load_req = 1'b0;
        clear_acc();

        vt.push_back('{32'h76543210, 8'h00, 8'hFF, 8'hFF, 8'hC0, 8'hA4});
        vt.push_back('{32'h76543210, 8'h04, 8'h05, 8'h05, 8'hC0, 8'h24});
        vt.push_back('{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'h0E, 8'h0E});
        vt.push_back('{32'h89ABCDEF, 8'h00, 8'hF0, 8'hF0, 8'hFF, 8'hFF});
`ifdef SSEG_LZ_BLANK_EN
        vt.push_back('{32'h000000A5, 8'h00, 8'hFF, 8'h03, 8'h92, 8'hFF});
        vt.push_back('{32'h00000000, 8'h00, 8'hFF, 8'h01, 8'hC0, 8'hFF});
`else
        vt.push_back('{32'h000000A5, 8'h00, 8'hFF, 8'hFF, 8'h92, 8'hC0});
        vt.push_back('{32'h00000000, 8'h00, 8'h01, 8'h01, 8'hC0, 8'hFF});
`endif

        // Reset state and dark idle display
        repeat (3) tick();
        check("rst_an", 32'(sseg_an), 32'hFF);
        check("rst_ca", 32'(sseg_ca), 32'hFF);
        check("rst_ack", 32'(load_ack), 32'h0);
        rst_n = 1'b1;
        clear_acc();
        repeat (130) tick();
        check("idle_dark", 32'(seen_low), 32'h00);
        check("idle_frames", 32'(frame_cnt), 32'd2);

        // Basic load with slot-by-slot timing after the acknowledge
        clear_acc();
        do_load(32'h76543210, 8'h00, 8'hFF);
        exp_an = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
        exp_ca = '{8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hF9};
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("slot_an%0d", k), 32'(sseg_an), 32'(exp_an[k]));
            check($sformatf("slot_ca%0d", k), 32'(sseg_ca), 32'(exp_ca[k]));
        end
        repeat (60) tick();
        check("single_ack", 32'(ack_cnt), 32'd1);

        // Table-driven loads, each observed over one full frame
        for (int v = 0; v < vt.size(); v++) begin
            do_load(vt[v].data, vt[v].dp, vt[v].mask);
            tick();
            clear_acc();
            repeat (64) tick();
            check($sformatf("v%0d_seen", v), 32'(seen_low), 32'(vt[v].seen));
            check($sformatf("v%0d_d0", v), 32'(d0_ca), 32'(vt[v].d0));
            check($sformatf("v%0d_d2", v), 32'(d2_ca), 32'(vt[v].d2));
            check($sformatf("v%0d_noack", v), 32'(ack_cnt), 32'd0);
        end

        // Mid-frame request: old digits finish the frame, new data from digit 0
        do_load(32'h76543210, 8'h00, 8'hFF);
        wait_an(8'hF7, "wait_d3");
        clear_acc();
        data     = 32'hFFFFFFFF;
        dp       = 8'h00;
        en_mask  = 8'hFF;
        load_req = 1'b1;
        wait_ack("mid_ack");
        load_req = 1'b0;
        tick();
        check("mid_old_d7", 32'(d7_ca), 32'hF8);
        check("mid_no_d0", 32'(d0_ca), 32'hFF);
        clear_acc();
        repeat (9) tick();
        check("mid_new_d0", 32'(d0_ca), 32'h8E);

        // Reset while digit 2 is driven
        wait_an(8'hFB, "wait_d2");
        rst_n = 1'b0;
        tick();
        check("mrst_an", 32'(sseg_an), 32'hFF);
        check("mrst_ca", 32'(sseg_ca), 32'hFF);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_acc();
        repeat (130) tick();
        check("mrst_dark", 32'(seen_low), 32'h00);
        check("mrst_frames", 32'(frame_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
